// File: rtl/bri_drive_gen.sv
// H-bridge transmit drive sequencer.
// Turns the 4f tick strobe into mutually exclusive up/down gate enables with
// runtime half-period, dead time, start phase, half-frequency gaps and an
// optional burst cycle count with a completion pulse.
module bri_drive_gen #(
    parameter int TICK_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_dds,
    input  logic              rst,
    input  logic              clk_4f_en,
    input  logic              en,
    input  logic              half_mode,
    input  logic [1:0]        phase_sel,
    input  logic [TICK_W-1:0] half_ticks,
    input  logic [TICK_W-1:0] dead_ticks,
    input  logic [CNT_W-1:0]  n_cycles,
    output logic              up,
    output logic              down,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cyc_cnt
);

    // One extra bit so the 2H gap length always fits the tick counter.
    localparam int CW = TICK_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QDLY  = 3'd1,
        POS   = 3'd2,
        DEADP = 3'd3,
        GAPP  = 3'd4,
        NEG   = 3'd5,
        DEADN = 3'd6,
        GAPN  = 3'd7
    } state_t;

    state_t            state_reg, state_next, adv_state;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [TICK_W-1:0] h_reg, d_reg;
    logic              half_reg;
    logic [CNT_W-1:0]  n_reg;
    logic [CNT_W-1:0]  cyc_reg, cyc_next, cyc_inc;
    logic              second_reg, second_next;
    logic              armed_reg, armed_next;
    logic              done_reg, done_next;
    logic              up_reg, down_reg;
    logic              latch_cfg, enter, group_end;

    // Sanitised live inputs, used only on the start edge.
    logic [TICK_W-1:0] in_h, in_d;
    // Configuration in effect for duration lookups: live inputs while idle,
    // latched copy while a burst is running.
    logic [TICK_W-1:0] cfg_h, cfg_d;
    logic              cfg_half;

    assign in_h     = (half_ticks == '0) ? TICK_W'(1) : half_ticks;
    assign in_d     = (dead_ticks >= in_h) ? (in_h - TICK_W'(1)) : dead_ticks;
    assign cfg_h    = (state_reg == IDLE) ? in_h : h_reg;
    assign cfg_d    = (state_reg == IDLE) ? in_d : d_reg;
    assign cfg_half = (state_reg == IDLE) ? half_mode : half_reg;
    assign cyc_inc  = (cyc_reg == '1) ? cyc_reg : (cyc_reg + CNT_W'(1));

    // Successor of the current state once its tick count expires; flags the
    // edge that closes a POS or NEG group (dead time and gap included).
    always_comb begin
        adv_state = IDLE;
        group_end = 1'b0;
        case (state_reg)
            QDLY:  adv_state = POS;
            POS: begin
                if (cfg_d != '0)   adv_state = DEADP;
                else if (cfg_half) adv_state = GAPP;
                else begin
                    adv_state = NEG;
                    group_end = 1'b1;
                end
            end
            DEADP: begin
                if (cfg_half) adv_state = GAPP;
                else begin
                    adv_state = NEG;
                    group_end = 1'b1;
                end
            end
            GAPP: begin
                adv_state = NEG;
                group_end = 1'b1;
            end
            NEG: begin
                if (cfg_d != '0)   adv_state = DEADN;
                else if (cfg_half) adv_state = GAPN;
                else begin
                    adv_state = POS;
                    group_end = 1'b1;
                end
            end
            DEADN: begin
                if (cfg_half) adv_state = GAPN;
                else begin
                    adv_state = POS;
                    group_end = 1'b1;
                end
            end
            GAPN: begin
                adv_state = POS;
                group_end = 1'b1;
            end
            default: adv_state = IDLE;
        endcase
    end

    // Next-state, tick counter reload, cycle counting, done and re-arm.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        cyc_next    = cyc_reg;
        second_next = second_reg;
        armed_next  = armed_reg;
        done_next   = 1'b0;
        latch_cfg   = 1'b0;
        enter       = 1'b0;

        if (!en) begin
            // Abort: drop to idle immediately; count holds, no done.
            state_next = IDLE;
            armed_next = 1'b1;
        end else if (clk_4f_en) begin
            if (state_reg == IDLE) begin
                if (armed_reg) begin
                    latch_cfg   = 1'b1;
                    cyc_next    = '0;
                    second_next = 1'b0;
                    enter       = 1'b1;
                    if (phase_sel == 2'b01 && in_h[TICK_W-1:1] != '0)
                        state_next = QDLY;
                    else if (phase_sel == 2'b10)
                        state_next = NEG;
                    else
                        state_next = POS;
                end
            end else if (cnt_reg > CW'(1)) begin
                cnt_next = cnt_reg - CW'(1);
            end else begin
                enter      = 1'b1;
                state_next = adv_state;
                if (group_end) begin
                    if (second_reg) begin
                        cyc_next    = cyc_inc;
                        second_next = 1'b0;
                        if (n_reg != '0 && cyc_inc == n_reg) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                            armed_next = 1'b0;
                            enter      = 1'b0;
                        end
                    end else begin
                        second_next = 1'b1;
                    end
                end
            end
        end

        if (enter) begin
            case (state_next)
                QDLY:         cnt_next = {2'b00, cfg_h[TICK_W-1:1]};
                POS, NEG:     cnt_next = {1'b0, cfg_h - cfg_d};
                DEADP, DEADN: cnt_next = {1'b0, cfg_d};
                GAPP, GAPN:   cnt_next = {cfg_h, 1'b0};
                default:      cnt_next = '0;
            endcase
        end
    end

    // State, configuration latch and registered outputs decoded from next state.
    always_ff @(posedge clk_dds) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            h_reg      <= '0;
            d_reg      <= '0;
            half_reg   <= 1'b0;
            n_reg      <= '0;
            cyc_reg    <= '0;
            second_reg <= 1'b0;
            armed_reg  <= 1'b1;
            done_reg   <= 1'b0;
            up_reg     <= 1'b0;
            down_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            cyc_reg    <= cyc_next;
            second_reg <= second_next;
            armed_reg  <= armed_next;
            done_reg   <= done_next;
            up_reg     <= (state_next == POS);
            down_reg   <= (state_next == NEG);
            if (latch_cfg) begin
                h_reg    <= in_h;
                d_reg    <= in_d;
                half_reg <= half_mode;
                n_reg    <= n_cycles;
            end
        end
    end

    assign up      = up_reg;
    assign down    = down_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign cyc_cnt = cyc_reg;

endmodule

// File: tb/tb_bri_drive_gen.sv
// Testbench for bri_drive_gen: table-driven bursts, hand-written corner
// sequences and random stimulus, all checked every clock against a
// queue-based model of the expected tick-by-tick drive waveform.
module tb_bri_drive_gen;

    logic        clk_dds = 1'b0;
    logic        rst = 1'b1;
    logic        clk_4f_en = 1'b0;
    logic        en = 1'b0;
    logic        half_mode = 1'b0;
    logic [1:0]  phase_sel = 2'b00;
    logic [7:0]  half_ticks = 8'd2;
    logic [7:0]  dead_ticks = 8'd0;
    logic [15:0] n_cycles = 16'd0;
    logic        up, down, busy, done;
    logic [15:0] cyc_cnt;

    int checks = 0;
    int failures = 0;

    bri_drive_gen #(.TICK_W(8), .CNT_W(16)) dut (
        .clk_dds   (clk_dds),
        .rst       (rst),
        .clk_4f_en (clk_4f_en),
        .en        (en),
        .half_mode (half_mode),
        .phase_sel (phase_sel),
        .half_ticks(half_ticks),
        .dead_ticks(dead_ticks),
        .n_cycles  (n_cycles),
        .up        (up),
        .down      (down),
        .busy      (busy),
        .done      (done),
        .cyc_cnt   (cyc_cnt)
    );

    always #5 clk_dds = ~clk_dds;

    // ---------------- reference model ----------------
    // At burst start the whole expected waveform (one entry per tick edge)
    // is laid out as a queue from the segment lengths; each tick pops one.
    typedef struct {
        logic        up;
        logic        down;
        logic        busy;
        logic        done;
        logic [15:0] cyc;
    } ent_t;

    ent_t        q[$];
    logic        m_up = 0, m_down = 0, m_busy = 0, m_done = 0;
    logic [15:0] m_cyc = 0;
    bit          m_run = 0, m_armed = 1, m_half = 0, m_first_pos = 1;
    int          m_h = 1, m_d = 0, m_n = 0;
    logic [15:0] b_cyc = 0;

    function automatic void push_n(int cnt, logic u, logic d);
        for (int i = 0; i < cnt; i++) q.push_back('{u, d, 1'b1, 1'b0, b_cyc});
    endfunction

    function automatic void push_group(bit pos);
        push_n(m_h - m_d, pos, !pos);
        push_n(m_d, 1'b0, 1'b0);
        if (m_half) push_n(2 * m_h, 1'b0, 1'b0);
    endfunction

    function automatic void push_pair();
        push_group(m_first_pos);
        push_group(!m_first_pos);
        if (b_cyc != 16'hffff) b_cyc = b_cyc + 16'd1;
        if (m_n != 0 && int'(b_cyc) == m_n) q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, b_cyc});
    endfunction

    function automatic void model_start();
        m_h = (half_ticks == 0) ? 1 : int'(half_ticks);
        m_d = (int'(dead_ticks) >= m_h) ? m_h - 1 : int'(dead_ticks);
        m_half = half_mode;
        m_n = int'(n_cycles);
        m_first_pos = (phase_sel != 2'b10);
        b_cyc = 0;
        q.delete();
        if (phase_sel == 2'b01) push_n(m_h / 2, 1'b0, 1'b0);
        for (int i = 0; i < m_n; i++) push_pair();
        m_run = 1;
    endfunction

    function automatic void model_clk();
        ent_t e;
        if (rst) begin
            q.delete();
            m_run = 0; m_armed = 1;
            m_up = 0; m_down = 0; m_busy = 0; m_done = 0; m_cyc = 0;
        end else if (!en) begin
            q.delete();
            m_run = 0; m_armed = 1;
            m_up = 0; m_down = 0; m_busy = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (clk_4f_en) begin
                if (!m_run && m_armed) model_start();
                if (m_run) begin
                    if (m_n == 0 && q.size() < 8) push_pair();
                    e = q.pop_front();
                    m_up = e.up; m_down = e.down; m_busy = e.busy;
                    m_done = e.done; m_cyc = e.cyc;
                    if (e.done) begin
                        m_run = 0;
                        m_armed = 0;
                    end
                end
            end
        end
    endfunction

    // ---------------- checking helpers ----------------
    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // One clock: model follows the edge, DUT sampled 1 time unit later.
    task automatic step();
        @(posedge clk_dds);
        model_clk();
        #1;
        chk("up", int'(up), int'(m_up));
        chk("down", int'(down), int'(m_down));
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("cyc_cnt", int'(cyc_cnt), int'(m_cyc));
        chk("up_and_down", int'(up & down), 0);
    endtask

    typedef struct {
        logic        half;
        logic [1:0]  ph;
        logic [7:0]  h;
        logic [7:0]  d;
        logic [15:0] n;
        int          per;
        logic        up0;
        logic        dn0;
        int          len;
    } vec_t;

    // Runs one counted burst; checks first-tick drive, the tick index of the
    // done edge and the final count. Inputs are scrambled after the start
    // edge to show the burst uses the latched configuration.
    task automatic run_vec(input int idx, input vec_t v);
        int ticks;
        bit got;
        en = 1'b0; clk_4f_en = 1'b0;
        step();
        half_mode = v.half; phase_sel = v.ph; half_ticks = v.h;
        dead_ticks = v.d; n_cycles = v.n; en = 1'b1;
        ticks = -1; got = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            clk_4f_en = ((c % v.per) == 0);
            step();
            if (clk_4f_en) begin
                ticks++;
                if (ticks == 0) begin
                    chk($sformatf("vec%0d_first_up", idx), int'(up), int'(v.up0));
                    chk($sformatf("vec%0d_first_down", idx), int'(down), int'(v.dn0));
                    half_ticks = 8'($urandom); dead_ticks = 8'($urandom);
                    phase_sel = 2'($urandom); half_mode = 1'($urandom);
                    n_cycles = 16'($urandom_range(1, 9));
                end
                if (done) got = 1;
            end
        end
        chk($sformatf("vec%0d_burst_len", idx), got ? ticks : -1, v.len);
        chk($sformatf("vec%0d_cyc_final", idx), int'(cyc_cnt), int'(v.n));
        $display("vec %0d: H=%0d D=%0d half=%0d ph=%0d n=%0d len=%0d", idx, v.h, v.d, v.half, v.ph, v.n, ticks);
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{1'b0, 2'b00, 8'd2, 8'd0, 16'd3, 1, 1'b1, 1'b0, 12};
        vt[1] = '{1'b1, 2'b00, 8'd2, 8'd0, 16'd1, 1, 1'b1, 1'b0, 12};
        vt[2] = '{1'b0, 2'b10, 8'd4, 8'd1, 16'd2, 4, 1'b0, 1'b1, 16};
        vt[3] = '{1'b0, 2'b01, 8'd4, 8'd0, 16'd1, 1, 1'b0, 1'b0, 10};
        vt[4] = '{1'b0, 2'b00, 8'd4, 8'd7, 16'd1, 1, 1'b1, 1'b0, 8};
        vt[5] = '{1'b0, 2'b01, 8'd0, 8'd0, 16'd2, 1, 1'b1, 1'b0, 4};
        vt[6] = '{1'b1, 2'b11, 8'd3, 8'd1, 16'd1, 2, 1'b1, 1'b0, 18};

        // Reset state.
        rst = 1'b1; en = 1'b1; clk_4f_en = 1'b1;
        step(); step();
        chk("reset_up", int'(up), 0);
        chk("reset_down", int'(down), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_cyc", int'(cyc_cnt), 0);
        rst = 1'b0; en = 1'b0; clk_4f_en = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

        // No restart after done while en stays high; re-arm with an en pulse.
        run_vec(0, vt[0]);
        clk_4f_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_restart_busy", int'(busy), 0);
        end
        half_mode = 1'b0; phase_sel = 2'b00; half_ticks = 8'd2;
        dead_ticks = 8'd0; n_cycles = 16'd0;
        en = 1'b0; clk_4f_en = 1'b0;
        step();
        en = 1'b1; clk_4f_en = 1'b1;
        step();
        chk("rearm_busy", int'(busy), 1);
        chk("rearm_up", int'(up), 1);
        chk("rearm_cyc", int'(cyc_cnt), 0);
        step(); step();
        chk("midneg_down", int'(down), 1);
        $display("seq: re-arm then rst mid-NEG");
        rst = 1'b1;
        step();
        chk("rst_mid_neg_up", int'(up), 0);
        chk("rst_mid_neg_down", int'(down), 0);
        chk("rst_mid_neg_busy", int'(busy), 0);
        rst = 1'b0; en = 1'b0; clk_4f_en = 1'b0;
        step();

        // Continuous run, abort mid-POS on a non-tick clock, then restart.
        en = 1'b1; clk_4f_en = 1'b1;
        for (int i = 0; i < 9; i++) step();
        chk("cont_up", int'(up), 1);
        chk("cont_cyc", int'(cyc_cnt), 2);
        en = 1'b0; clk_4f_en = 1'b0;
        step();
        chk("abort_up", int'(up), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_cyc_hold", int'(cyc_cnt), 2);
        en = 1'b1; clk_4f_en = 1'b1;
        step();
        chk("restart_up", int'(up), 1);
        chk("restart_cyc", int'(cyc_cnt), 0);
        $display("seq: continuous abort and restart");

        // Random stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 49) != 0);
            clk_4f_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) begin
                half_mode = 1'($urandom);
                phase_sel = 2'($urandom);
                half_ticks = 8'($urandom_range(0, 6));
                dead_ticks = 8'($urandom_range(0, 7));
                n_cycles = 16'($urandom_range(0, 3));
            end
            step();
        end
        $display("random: 4000 clocks");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
